costas_loop_param: RTL
======================

// Module: costas_loop_param
// PURPOSE
//  Parametrised Costas carrier loop: integrate-and-dump of I/Q mixer outputs, selectable phase
//  discriminator, PI loop filter, lock detector and data-bit decision. Sits between the carrier
//  mixer and the carrier NCO. Successor of the fixed 10000-sample product loop: adds input
//  qualification, saturating arithmetic, discriminator modes, PI gains, lock flag, valid strobes.
// PARAMETERS
//  IN_W       16     signed width of in_i / in_q
//  ACC_W      32     signed width of accumulators, prompts, error, integrator, correction
//  N_INT      10000  accepted samples per integration period (>=2)
//  ERR_SHIFT  31     arithmetic right shift of 2*ACC_W product in mode 0
//  KP_SHIFT   8      proportional gain = 2^-KP_SHIFT
//  KI_SHIFT   16     integral gain = 2^-KI_SHIFT
//  LOCK_CNT   8      consecutive-lock dumps needed to assert lock (>=1)
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      in_i/in_q valid this cycle
//  in_i         in   IN_W   in-phase sample, signed
//  in_q         in   IN_W   quadrature sample, signed
//  mode         in   2      discriminator: 0 I*Q, 1 sign(I)*Q, 2/3 hold
//  dump_valid   out  1      one-cycle pulse: prompt_i/q, data_bit updated
//  prompt_i     out  ACC_W  integrated I of last period
//  prompt_q     out  ACC_W  integrated Q of last period
//  data_bit     out  1      1 when prompt_i >= 0
//  corr_valid   out  1      one-cycle pulse: correction updated
//  correction   out  ACC_W  NCO frequency correction, signed
//  lock         out  1      carrier lock indicator
// BEHAVIOUR
//  Reset: all outputs, accumulators, sample counter, integrator, lock counter = 0.
//  rst mid-period discards partial sums; counting restarts from 0 on next valid sample.
//  Integration: per cycle with in_valid=1, acc_i+=sext(in_i), acc_q+=sext(in_q), cnt++.
//   in_valid=0: acc and cnt hold. All adds saturate to ACC_W signed limits, never wrap.
//  Dump: on the valid sample with cnt==N_INT-1: prompt = sat(acc+sample), acc<=0, cnt<=0,
//   data_bit updated; dump_valid=1 in following cycle (latency 1 from last sample).
//   A valid sample in the dump cycle starts the next period (no sample lost).
//  Stage D (cycle after dump_valid): err from prompts, mode sampled here.
//   mode 0: err = sat_ACC((prompt_i*prompt_q) >>> ERR_SHIFT), full 2*ACC_W product.
//   mode 1: err = prompt_q if prompt_i>=0 else sat(-prompt_q) (sign(0)=+1).
//   mode 2/3: err = 0; integrator frozen, correction = integrator value.
//  Stage F (next cycle): integ = sat(integ + (err>>>KI_SHIFT)) (mode 0/1 only);
//   correction = sat(integ_new + (err>>>KP_SHIFT)); corr_valid=1 this cycle.
//   corr_valid lags dump_valid by exactly 2 cycles. >>> is floor (arithmetic) shift.
//  Lock: at each dump, cond = |prompt_i| >= 2*|prompt_q| (|x| saturating, compare ACC_W+1 bits).
//   cond: lcnt = min(lcnt+1, LOCK_CNT), else lcnt = max(lcnt-1, 0).
//   lock set when lcnt reaches LOCK_CNT, cleared when lcnt reaches 0 (hysteresis).
//   lock and lcnt update in the dump_valid cycle.
//  Outputs hold between strobes. Mode change mid-period affects only the next stage D.
// TESTING
//  N_INT=4, in_i=100,in_q=0 every cycle -> dump_valid after 4th sample, prompt_i=400,
//   prompt_q=0, data_bit=1, err=0, corr_valid 2 cycles later, lock after LOCK_CNT dumps.
//  ACC_W=20,N_INT=64, in_i=32767 -> prompt_i=524287 (saturated, no wrap), in_i=-32768 -> -524288.
//  mode 1, KP_SHIFT=2,KI_SHIFT=4, prompt_i=-400,prompt_q=-200 -> err=200 -> integ=12,
//   correction=62; mode 0 ERR_SHIFT=4 same prompts -> err=5000.
//  in_valid toggling 1010..., N_INT=4 -> dump after 4th valid sample (cycle 7), sums match gapless run.
//  lock hysteresis, LOCK_CNT=3: 3 locked dumps -> lock=1; 2 unlocked -> lock stays 1; 3rd -> lock=0.
//  rst asserted at sample 2 of period -> all outputs 0; next dump requires N_INT fresh samples.

Source files
------------

// File: rtl/costas_loop_param.sv
// costas_loop_param: integrate-and-dump Costas carrier loop with selectable discriminator, PI filter and lock detector
module costas_loop_param #(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 32,
  parameter int N_INT     = 10000,
  parameter int ERR_SHIFT = 31,
  parameter int KP_SHIFT  = 8,
  parameter int KI_SHIFT  = 16,
  parameter int LOCK_CNT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_i,
  input  logic signed [IN_W-1:0]  in_q,
  input  logic [1:0]              mode,
  output logic                    dump_valid,
  output logic signed [ACC_W-1:0] prompt_i,
  output logic signed [ACC_W-1:0] prompt_q,
  output logic                    data_bit,
  output logic                    corr_valid,
  output logic signed [ACC_W-1:0] correction,
  output logic                    lock
);
  localparam int CW = $clog2(N_INT);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int PW = 2 * ACC_W;
  localparam logic signed [ACC_W-1:0] MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [PW-1:0]    MAX2 = MAX;
  localparam logic signed [PW-1:0]    MIN2 = MIN;

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a, input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    return (s[ACC_W] != s[ACC_W-1]) ? (s[ACC_W] ? MIN : MAX) : s[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_neg(input logic signed [ACC_W-1:0] a);
    return (a == MIN) ? MAX : -a;
  endfunction

  logic signed [ACC_W-1:0] r_acc_i, r_acc_q, r_err, r_integ;
  logic [CW-1:0]           r_cnt;
  logic [LW-1:0]           r_lcnt;
  logic                    r_d_valid;

  logic signed [ACC_W-1:0] w_si, w_sq, w_sum_i, w_sum_q, w_abs_i, w_abs_q;
  logic signed [ACC_W-1:0] w_e0, w_e1, w_err, w_integ_n;
  logic signed [PW-1:0]    w_prod, w_psh;
  logic [LW-1:0]           w_lcnt_n;
  logic                    w_last, w_cond;

  assign w_si      = ACC_W'(in_i);
  assign w_sq      = ACC_W'(in_q);
  assign w_sum_i   = sat_add(r_acc_i, w_si);
  assign w_sum_q   = sat_add(r_acc_q, w_sq);
  assign w_last    = in_valid && (r_cnt == CW'(N_INT - 1));
  assign w_abs_i   = w_sum_i[ACC_W-1] ? sat_neg(w_sum_i) : w_sum_i;
  assign w_abs_q   = w_sum_q[ACC_W-1] ? sat_neg(w_sum_q) : w_sum_q;
  assign w_cond    = {1'b0, w_abs_i} >= {w_abs_q, 1'b0};
  assign w_lcnt_n  = w_cond ? ((r_lcnt == LW'(LOCK_CNT)) ? r_lcnt : r_lcnt + 1'b1)
                            : ((r_lcnt == '0) ? r_lcnt : r_lcnt - 1'b1);
  assign w_prod    = PW'(prompt_i) * PW'(prompt_q);
  assign w_psh     = w_prod >>> ERR_SHIFT;
  assign w_e0      = (w_psh > MAX2) ? MAX : (w_psh < MIN2) ? MIN : w_psh[ACC_W-1:0];
  assign w_e1      = prompt_i[ACC_W-1] ? sat_neg(prompt_q) : prompt_q;
  assign w_err     = (mode == 2'd0) ? w_e0 : (mode == 2'd1) ? w_e1 : '0;
  assign w_integ_n = sat_add(r_integ, r_err >>> KI_SHIFT);

  // accumulate qualified samples, dump prompts and update lock hysteresis at period end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_i    <= '0;
      r_acc_q    <= '0;
      r_cnt      <= '0;
      r_lcnt     <= '0;
      dump_valid <= 1'b0;
      prompt_i   <= '0;
      prompt_q   <= '0;
      data_bit   <= 1'b0;
      lock       <= 1'b0;
    end else begin
      dump_valid <= w_last;
      if (in_valid) begin
        r_acc_i <= w_last ? '0 : w_sum_i;
        r_acc_q <= w_last ? '0 : w_sum_q;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_last) begin
        prompt_i <= w_sum_i;
        prompt_q <= w_sum_q;
        data_bit <= ~w_sum_i[ACC_W-1];
        r_lcnt   <= w_lcnt_n;
        lock     <= (w_lcnt_n == LW'(LOCK_CNT)) | (lock & (w_lcnt_n != '0));
      end
    end
  end

  // discriminator one cycle after dump, PI loop filter the cycle after that
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_valid  <= 1'b0;
      r_err      <= '0;
      r_integ    <= '0;
      corr_valid <= 1'b0;
      correction <= '0;
    end else begin
      r_d_valid  <= dump_valid;
      corr_valid <= r_d_valid;
      if (dump_valid) r_err <= w_err;
      if (r_d_valid) begin
        r_integ    <= w_integ_n;
        correction <= sat_add(w_integ_n, r_err >>> KP_SHIFT);
      end
    end
  end
endmodule
